dmem_controller: RTL
====================

Name: dmem_controller

Overview:
- Data-memory slave that sits directly downstream of the single-cycle rv32i core's data port.
- Consumes the core's address, read/write strobes, byte mask and aligned store data; returns `op_data_valid` and a full 32-bit read word.
- Contains a byte-maskable word RAM, a small MMIO region (LED register, free-running cycle counter) and programmable wait states.
- The core stalls until valid. Byte/half extraction stays in the core.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 0, extra cycles inserted before each response; legal range 0..15.
- MMIO_BASE, 32'h80000000, base of the MMIO region; decoded on addr[31:4].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ip_data_addr  in  32  byte address from core; bits [1:0] ignored for word selection.
- ip_data_wr  in  1  write request.
- ip_data_mask  in  4  byte-lane enables for writes; ignored on reads.
- ip_data_from_proc  in  32  lane-aligned store data.
- ip_data_rd  in  1  read request.
- op_data_valid  out  1  one-cycle response strobe; the core commits the access in this cycle.
- op_data_to_proc  out  32  read word; valid only while op_data_valid=1.
- op_led  out  8  LED register contents.
- op_bus_error  out  1  one-cycle pulse, concurrent with op_data_valid, for unmapped accesses.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - state=IDLE
  - op_data_valid=0, op_bus_error=0, op_data_to_proc=0
  - op_led=0, cycle counter=0
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if ip_data_rd|ip_data_wr, capture addr/wr/mask/data and go to WAIT. If WAIT_STATES=0, go directly to RESP. Otherwise stay in IDLE.
  - WAIT: a counter loaded with WAIT_STATES-1 decrements each cycle; at 0, go to RESP.
  - RESP: op_data_valid=1 for exactly this cycle, then unconditionally go to IDLE.
  - A request still asserted in the IDLE cycle after RESP is a new request. The core's next instruction may legally be another load or store.
- Latency: a request accepted in cycle N gets op_data_valid in cycle N+1+WAIT_STATES. No back-to-back responses; the minimum request period is 2+WAIT_STATES cycles.
- Captured values are used throughout; input changes after acceptance are ignored.
- Simultaneous rd and wr: treated as a write; op_data_to_proc returns 0.
- Commit timing: writes commit, and read data is registered, on the clock edge entering RESP.
  - Consequence: a read immediately following a write to the same word returns the new data.
- RAM access (addr < 4*DEPTH_WORDS, word index addr[31:2]):
  - Write updates byte lane i iff mask[i]=1.
  - Mask 4'b0000 writes nothing and raises no error.
- MMIO (addr[31:4]==MMIO_BASE[31:4]):
  - +0x0, LED:
    - Read returns {24'b0, op_led}.
    - Write with mask[0]=1 loads data[7:0]; other lanes are ignored.
  - +0x4, cycle counter:
    - Read returns the counter value as of the edge entering RESP.
    - Writes are silently ignored, no error.
    - The counter increments every cycle from reset and wraps 32'hFFFFFFFF -> 0.
  - +0x8, +0xC: unmapped.
- Unmapped address (anything else, including RAM overrun):
  - Reads return 0, writes are dropped.
  - op_bus_error=1 in the RESP cycle.
  - The response still completes, so the core never hangs.
- Reset mid-operation (in WAIT or RESP): return to IDLE immediately.
  - A pending write is discarded if the reset edge precedes RESP entry.
  - No valid is issued for the aborted request.
- Width rules: address decode is exact on 32 bits; no aliasing of RAM above DEPTH_WORDS.

Test Plan:
1. Basic write/read, WAIT_STATES=0: write 0xDEADBEEF, mask 4'b1111, to 0x10; then read 0x10 -> valid in cycle N+1 for both accesses, read data 0xDEADBEEF, op_bus_error=0.
2. Byte masking:
   - Preload 0x11223344 at 0x20.
   - Write 0xAABBCCDD with mask 4'b0100 -> read returns 0x11BB3344.
   - Then write with mask 4'b0000 -> read still returns 0x11BB3344.
3. Wait states, WAIT_STATES=3: read accepted in cycle 10 -> op_data_valid high only in cycle 14. A request held high continuously is re-accepted in cycle 15 -> valid in cycle 19.
4. MMIO:
   - Write 0x000000A5 to 0x80000000 -> op_led=0xA5.
   - Write with mask 4'b1110 -> op_led unchanged.
   - Two reads of 0x80000004 spaced 5 cycles apart differ by exactly 5.
   - A write to 0x80000004 is ignored, bus_error=0.
5. Errors:
   - Read at 4*DEPTH_WORDS -> data 0, op_bus_error pulses with valid.
   - Write to 0x80000008 -> error pulse.
   - Rd+wr together to 0x30 -> 0x30 written, returned data 0.
6. Reset mid-op, WAIT_STATES=3:
   - Accept a write of 0x12345678 to 0x40, assert reset in the second WAIT cycle.
   - Required: valid stays 0, op_led=0, state returns to IDLE, and a later read of 0x40 returns the prior contents.

Source files
------------

// File: rtl/dmem_controller.sv
// Data-memory slave for the rv32i core data port.
// Byte-maskable word RAM, LED/cycle-counter MMIO and programmable wait states.
module dmem_controller #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h80000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic [7:0]  op_led,
    output logic        op_bus_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_next;

    logic [31:0] r_addr;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;

    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_led;
    logic [31:0] r_cycle;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_idle;
    logic [31:0] w_addr;
    logic        w_wr;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic        w_is_ram;
    logic        w_is_mmio;
    logic        w_is_led;
    logic        w_is_cnt;
    logic        w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0] w_rdata;

    // With zero wait states the commit edge is the accept edge, so the
    // live inputs stand in for the captured request while idle.
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && (ip_data_rd || ip_data_wr);
    assign w_addr   = w_idle ? ip_data_addr      : r_addr;
    assign w_wr     = w_idle ? ip_data_wr        : r_wr;
    assign w_mask   = w_idle ? ip_data_mask      : r_mask;
    assign w_wdata  = w_idle ? ip_data_from_proc : r_wdata;

    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    assign w_is_ram  = {1'b0, w_addr} < RAM_BYTES;
    assign w_is_mmio = (w_addr[31:4] == MMIO_BASE[31:4]);
    assign w_is_led  = w_is_mmio && (w_addr[3:2] == 2'd0);
    assign w_is_cnt  = w_is_mmio && (w_addr[3:2] == 2'd1);
    assign w_err     = !(w_is_ram || w_is_led || w_is_cnt);
    assign w_idx     = w_addr[IDX_W+1:2];

    // Read word selection; writes (including rd+wr) return zero.
    always_comb begin
        w_rdata = 32'd0;
        if (!w_wr) begin
            if (w_is_ram) begin
                w_rdata = r_mem[w_idx];
            end else if (w_is_led) begin
                w_rdata = {24'd0, r_led};
            end else if (w_is_cnt) begin
                w_rdata = r_cycle;
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next      = WAIT;
                        w_wcnt_next = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_wcnt_next = r_wcnt - 4'd1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, wait counter and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
            r_addr  <= 32'd0;
            r_wr    <= 1'b0;
            r_mask  <= 4'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (w_accept) begin
                r_addr  <= ip_data_addr;
                r_wr    <= ip_data_wr;
                r_mask  <= ip_data_mask;
                r_wdata <= ip_data_from_proc;
            end
        end
    end

    // Response data, error flag, LED register and cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_led   <= 8'd0;
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_enter_resp) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
                if (w_wr && w_is_led && w_mask[0]) begin
                    r_led <= w_wdata[7:0];
                end
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_wr && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign op_data_valid   = (r_state == RESP);
    assign op_bus_error    = (r_state == RESP) && r_err;
    assign op_data_to_proc = r_rdata;
    assign op_led          = r_led;

endmodule
